// File: rtl/ft2020_pcore.sv
// ft2020_pcore: single-issue, non-pipelined predicated RISC micro-core.
// FETCH -> EXEC -> (MEM | MULT) -> FETCH. Every instruction carries a predicate
// guard; a false guard annuls the instruction, which then only advances ip.
// Ports:
//   clk, rst         clock / asynchronous active-high reset
//   ip               fetch byte address
//   insn, insn_vld   instruction word and its valid (sampled in FETCH only)
//   mem_req, mem_we  data access request (held until mem_rdy) / store flag
//   mem_ad           data byte address
//   mem_dato         store data
//   mem_dati         load data
//   mem_rdy          access complete
module ft2020_pcore #(
  parameter int WID   = 32,
  parameter int AW    = 25,
  parameter int NPRED = 16,
  parameter int MULEN = 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic [AW-1:0]  ip,
  input  logic [31:0]    insn,
  input  logic           insn_vld,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_ad,
  output logic [WID-1:0] mem_dato,
  input  logic [WID-1:0] mem_dati,
  input  logic           mem_rdy
);
  localparam int SW = $clog2(WID);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, MULT} state_t;
  state_t state, nstate;

  logic [31:0]    ir;
  logic [WID-1:0] rf [1:30];
  logic [WID-1:0] sp;                 // r31
  logic [15:0]    pr;                 // bit 0 stays 1, bits >= NPRED stay 0

  logic [WID-1:0] mcand, mplier, macc, mprod;
  logic [SW-1:0]  mcnt;
  logic           mlast;

  logic [4:0]     op, rt, ra, rb;
  logic [7:0]     fn;
  logic [3:0]     pp, pt;
  logic [WID-1:0] a, b, t, imm, sum, res, ea, spm4;
  logic [SW-1:0]  sh;
  logic [AW-1:0]  ip4, tgt;
  logic [33:0]    jw;
  logic           guard, cond;
  logic           is_rr, is_alu, is_cmp, is_mul, is_ret, is_ld, is_st, is_jmp, is_jsr;
  logic           wen;
  logic [4:0]     wa;
  logic [WID-1:0] wd;

  function automatic logic [3:0] pmod(input logic [3:0] x);
    return 4'(32'(x) % NPRED);
  endfunction

  assign op   = ir[27:23];
  assign rt   = ir[22:18];
  assign ra   = ir[17:13];
  assign rb   = ir[12:8];
  assign fn   = ir[7:0];
  assign pp   = pmod(ir[31:28]);
  assign pt   = pmod(ir[21:18]);
  assign imm  = WID'($signed(ir[12:0]));
  assign sh   = b[SW-1:0];
  assign ip4  = ip + AW'(4);
  assign jw   = {ir, 2'b00};
  assign tgt  = AW'(jw);
  assign guard = pr[pp];

  always_comb begin
    a = (ra == 5'd0) ? '0 : (ra == 5'd31) ? sp : rf[ra];
    b = (rb == 5'd0) ? '0 : (rb == 5'd31) ? sp : rf[rb];
    t = (rt == 5'd0) ? '0 : (rt == 5'd31) ? sp : rf[rt];
  end

  assign sum  = a + b;
  assign ea   = a + imm;
  assign spm4 = sp - WID'(4);

  assign is_rr  = (op == 5'd0);
  assign is_cmp = is_rr && (fn[7:4] == 4'hF);
  assign is_mul = is_rr && (fn == 8'd19);
  assign is_ret = is_rr && (fn == 8'h80);
  assign is_ld  = (op == 5'd16);
  assign is_st  = (op == 5'd17);
  assign is_jmp = (op == 5'd22);
  assign is_jsr = (op == 5'd23);
  assign is_alu = (op == 5'd4) || (op == 5'd8) || (op == 5'd9) || (op == 5'd10) ||
                  (is_rr && (fn == 8'd4 || fn == 8'd5 || (fn >= 8'd8 && fn <= 8'd18)));

  always_comb begin
    res = '0;
    case (op)
      5'd4:  res = ea;
      5'd8:  res = a & imm;
      5'd9:  res = a | imm;
      5'd10: res = a ^ imm;
      default: begin
        case (fn)
          8'd4:    res = sum;
          8'd5:    res = a - b;
          8'd8:    res = a & b;
          8'd9:    res = a | b;
          8'd10:   res = a ^ b;
          8'd11:   res = a & ~b;
          8'd12:   res = ~(a & b);
          8'd13:   res = ~(a | b);
          8'd14:   res = ~(a ^ b);
          8'd15:   res = a | ~b;
          8'd16:   res = a << sh;
          8'd17:   res = a >> sh;
          8'd18:   res = $signed(a) >>> sh;
          default: res = '0;
        endcase
      end
    endcase
  end

  // Carry of a+b is recovered from the wrapped sum; parity of the sum needs only bit 0.
  always_comb begin
    cond = 1'b0;
    case (fn[3:0])
      4'd0:    cond = (a == b);
      4'd1:    cond = (a != b);
      4'd4:    cond = ($signed(a) <  $signed(b));
      4'd5:    cond = ($signed(a) >= $signed(b));
      4'd6:    cond = ($signed(a) <= $signed(b));
      4'd7:    cond = ($signed(a) >  $signed(b));
      4'd8:    cond = (a <  b);
      4'd9:    cond = (a >= b);
      4'd10:   cond = (a <= b);
      4'd11:   cond = (a >  b);
      4'd12:   cond = (sum < a);
      4'd14:   cond = a[0] ^ b[0];
      default: cond = 1'b0;
    endcase
  end

  assign mprod = macc + (mplier[0] ? mcand : '0);
  assign mlast = (mcnt == SW'(WID - 1));

  always_comb begin
    nstate = state;
    case (state)
      FETCH: if (insn_vld) nstate = EXEC;
      EXEC: begin
        nstate = FETCH;
        if (guard) begin
          if (is_ld || is_st || is_jsr || is_ret) nstate = MEM;
          else if (is_mul && MULEN != 0)          nstate = MULT;
        end
      end
      MEM:  if (mem_rdy) nstate = FETCH;
      MULT: if (mlast)   nstate = FETCH;
      default: nstate = FETCH;
    endcase
  end

  always_comb begin
    wen = 1'b0;
    wa  = rt;
    wd  = res;
    case (state)
      EXEC: wen = guard && is_alu;
      MEM:  if (mem_rdy && is_ld) begin
        wen = 1'b1;
        wd  = mem_dati;
      end
      MULT: if (mlast) begin
        wen = 1'b1;
        wd  = mprod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (wen && wa != 5'd0 && wa != 5'd31) rf[wa] <= wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip       <= '0;
      ir       <= '0;
      sp       <= '0;
      pr       <= 16'h0001;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_ad   <= '0;
      mem_dato <= '0;
      mcand    <= '0;
      mplier   <= '0;
      macc     <= '0;
      mcnt     <= '0;
    end else begin
      if (wen && wa == 5'd31) sp <= wd;
      case (state)
        FETCH: if (insn_vld) ir <= insn;
        EXEC: begin
          if (!guard) begin
            ip <= ip4;
          end else if (is_ld || is_st) begin
            mem_ad   <= AW'(ea);
            mem_we   <= is_st;
            mem_dato <= t;
            mem_req  <= 1'b1;
          end else if (is_jsr) begin
            // Return address goes below the current sp; ip jumps immediately.
            sp       <= spm4;
            mem_ad   <= AW'(spm4);
            mem_dato <= WID'(ip4);
            mem_we   <= 1'b1;
            mem_req  <= 1'b1;
            ip       <= tgt;
          end else if (is_ret) begin
            mem_ad   <= AW'(sp);
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            sp       <= sp + WID'(4);
          end else if (is_jmp) begin
            ip <= tgt;
          end else if (is_mul && MULEN != 0) begin
            mcand  <= a;
            mplier <= b;
            macc   <= '0;
            mcnt   <= '0;
          end else begin
            if (is_cmp && pt != 4'd0) pr[pt] <= cond;
            ip <= ip4;
          end
        end
        MEM: if (mem_rdy) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (is_ret) ip <= AW'(mem_dati);
          else if (is_ld || is_st) ip <= ip4;
        end
        MULT: begin
          macc   <= mprod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mcnt   <= mcnt + SW'(1);
          if (mlast) ip <= ip4;
        end
        default: ;
      endcase
    end
  end
endmodule
